// File: rtl/sample_ctrl_deframer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : sample_ctrl_deframer_if
// Description : Sample/control bus into the deframer and framed sample bus out.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface sample_ctrl_deframer_if #(
  parameter int LEN_W = 11
);
  logic             dataIn;
  logic             ctrlIn_start;
  logic             ctrlIn_end;
  logic             ctrlIn_valid;
  logic             dataOut;
  logic             validOut;
  logic             frameStart;
  logic             frameEnd;
  logic [LEN_W-1:0] frameLen;
  logic             lenValid;
  logic             errOut;

  modport master (
    output dataIn, ctrlIn_start, ctrlIn_end, ctrlIn_valid,
    input  dataOut, validOut, frameStart, frameEnd, frameLen, lenValid, errOut
  );

  modport slave (
    input  dataIn, ctrlIn_start, ctrlIn_end, ctrlIn_valid,
    output dataOut, validOut, frameStart, frameEnd, frameLen, lenValid, errOut
  );
endinterface
`default_nettype wire

// File: rtl/sample_ctrl_deframer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : sample_ctrl_deframer
// Description : Turns a start/end/valid sample stream into framed samples with
//               frame length reporting and protocol error strobes.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module sample_ctrl_deframer #(
  parameter int MAX_LEN = 1024,
  parameter int LEN_W   = 11
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               enb,
  sample_ctrl_deframer_if.slave   bus
);

  localparam logic [0:0]       c_IDLE     = 1'b0;
  localparam logic [0:0]       c_IN_FRAME = 1'b1;
  localparam logic [LEN_W-1:0] c_ONE      = LEN_W'(1);
  localparam logic [LEN_W-1:0] c_MAX      = LEN_W'(MAX_LEN);

  logic [0:0]       r_state;
  logic [LEN_W-1:0] r_cnt;
  logic             r_data_out;
  logic             r_valid_out;
  logic             r_frame_start;
  logic             r_frame_end;
  logic [LEN_W-1:0] r_frame_len;
  logic             r_len_valid;
  logic             r_err_out;

  logic [0:0]       w_state;
  logic [LEN_W-1:0] w_cnt;
  logic             w_data_out;
  logic             w_valid_out;
  logic             w_frame_start;
  logic             w_frame_end;
  logic [LEN_W-1:0] w_frame_len;
  logic             w_len_valid;
  logic             w_err_out;

  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_data_out    = 1'b0;
    w_valid_out   = 1'b0;
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    w_frame_len   = r_frame_len;
    w_len_valid   = 1'b0;
    w_err_out     = 1'b0;

    if (bus.ctrlIn_valid) begin
      if (bus.ctrlIn_start) begin
        // A start always opens a new frame; inside a frame it also aborts the old one.
        w_err_out     = (r_state == c_IN_FRAME);
        w_valid_out   = 1'b1;
        w_data_out    = bus.dataIn;
        w_frame_start = 1'b1;
        if (bus.ctrlIn_end) begin
          w_frame_end = 1'b1;
          w_frame_len = c_ONE;
          w_len_valid = 1'b1;
          w_state     = c_IDLE;
          w_cnt       = '0;
        end else begin
          w_state = c_IN_FRAME;
          w_cnt   = c_ONE;
        end
      end else begin
        case (r_state)
          c_IDLE: begin
            w_err_out = bus.ctrlIn_end;
          end
          default: begin
            if (r_cnt >= c_MAX) begin
              w_err_out = 1'b1;
              w_state   = c_IDLE;
              w_cnt     = '0;
            end else begin
              w_valid_out = 1'b1;
              w_data_out  = bus.dataIn;
              w_cnt       = r_cnt + c_ONE;
              if (bus.ctrlIn_end) begin
                w_frame_end = 1'b1;
                w_frame_len = r_cnt + c_ONE;
                w_len_valid = 1'b1;
                w_state     = c_IDLE;
                w_cnt       = '0;
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= c_IDLE;
      r_cnt         <= '0;
      r_data_out    <= 1'b0;
      r_valid_out   <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_frame_len   <= '0;
      r_len_valid   <= 1'b0;
      r_err_out     <= 1'b0;
    end else if (enb) begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_data_out    <= w_data_out;
      r_valid_out   <= w_valid_out;
      r_frame_start <= w_frame_start;
      r_frame_end   <= w_frame_end;
      r_frame_len   <= w_frame_len;
      r_len_valid   <= w_len_valid;
      r_err_out     <= w_err_out;
    end
  end

  assign bus.dataOut    = r_data_out;
  assign bus.validOut   = r_valid_out;
  assign bus.frameStart = r_frame_start;
  assign bus.frameEnd   = r_frame_end;
  assign bus.frameLen   = r_frame_len;
  assign bus.lenValid   = r_len_valid;
  assign bus.errOut     = r_err_out;

endmodule
`default_nettype wire

// File: tb/tb_sample_ctrl_deframer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_sample_ctrl_deframer
// Description : Bench for sample_ctrl_deframer; a default instance and a
//               MAX_LEN=4 instance run the same stimulus against a reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_sample_ctrl_deframer;

  logic clk = 1'b0;
  logic reset;
  logic enb;
  int   checks = 0;
  int   errors = 0;

  sample_ctrl_deframer_if #(.LEN_W(11)) ifa ();
  sample_ctrl_deframer_if #(.LEN_W(3))  ifb ();

  sample_ctrl_deframer #(.MAX_LEN(1024), .LEN_W(11)) dut_a (
    .clk(clk), .reset(reset), .enb(enb), .bus(ifa.slave)
  );
  sample_ctrl_deframer #(.MAX_LEN(4), .LEN_W(3)) dut_b (
    .clk(clk), .reset(reset), .enb(enb), .bus(ifb.slave)
  );

  always #5 clk = ~clk;

  // Reference model: m_len 0 means no open frame, otherwise samples taken so far.
  int   m_len [2];
  logic e_dout[2], e_vld[2], e_fs[2], e_fe[2], e_lv[2], e_err[2];
  int   e_len [2];

  function automatic int max_len(input int k);
    return (k == 0) ? 1024 : 4;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_len[k] = 0; e_len[k] = 0;
      e_dout[k] = 0; e_vld[k] = 0; e_fs[k] = 0; e_fe[k] = 0; e_lv[k] = 0; e_err[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input logic en, input logic v,
                            input logic s, input logic e, input logic d);
    if (!en) return;
    e_dout[k] = 0; e_vld[k] = 0; e_fs[k] = 0; e_fe[k] = 0; e_lv[k] = 0; e_err[k] = 0;
    if (!v) return;
    if (s) begin
      if (m_len[k] != 0) e_err[k] = 1;
      e_vld[k] = 1; e_dout[k] = d; e_fs[k] = 1;
      if (e) begin
        e_fe[k] = 1; e_lv[k] = 1; e_len[k] = 1; m_len[k] = 0;
      end else begin
        m_len[k] = 1;
      end
    end else if (m_len[k] == 0) begin
      if (e) e_err[k] = 1;
    end else if (m_len[k] >= max_len(k)) begin
      e_err[k] = 1; m_len[k] = 0;
    end else begin
      e_vld[k] = 1; e_dout[k] = d;
      m_len[k] = m_len[k] + 1;
      if (e) begin
        e_fe[k] = 1; e_lv[k] = 1; e_len[k] = m_len[k]; m_len[k] = 0;
      end
    end
  endtask

  function automatic logic [16:0] obs(input int k);
    if (k == 0)
      return {ifa.dataOut, ifa.validOut, ifa.frameStart, ifa.frameEnd,
              ifa.lenValid, ifa.errOut, ifa.frameLen};
    return {ifb.dataOut, ifb.validOut, ifb.frameStart, ifb.frameEnd,
            ifb.lenValid, ifb.errOut, 8'd0, ifb.frameLen};
  endfunction

  function automatic logic [16:0] expv(input int k);
    return {e_dout[k], e_vld[k], e_fs[k], e_fe[k], e_lv[k], e_err[k], 11'(e_len[k])};
  endfunction

  // Drive one cycle on both instances, advance the model, land #1 after the edge.
  task automatic step(input logic en, input logic v, input logic s,
                      input logic e, input logic d);
    enb = en;
    ifa.ctrlIn_valid = v; ifa.ctrlIn_start = s; ifa.ctrlIn_end = e; ifa.dataIn = d;
    ifb.ctrlIn_valid = v; ifb.ctrlIn_start = s; ifb.ctrlIn_end = e; ifb.dataIn = d;
    for (int k = 0; k < 2; k++) model_step(k, en, v, s, e, d);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step_inputs_idle();
    #2;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== 17'd0) begin
        errors++;
        $display("FAIL reset_async dut%0d: got %h expected %h", k, obs(k), 17'd0);
      end
    end
    @(posedge clk);
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== expv(k)) begin
        errors++;
        $display("FAIL reset_held dut%0d: got %h expected %h", k, obs(k), expv(k));
      end
    end
    reset = 1'b0;
  endtask

  task automatic step_inputs_idle();
    enb = 1'b1;
    ifa.ctrlIn_valid = 0; ifa.ctrlIn_start = 0; ifa.ctrlIn_end = 0; ifa.dataIn = 0;
    ifb.ctrlIn_valid = 0; ifb.ctrlIn_start = 0; ifb.ctrlIn_end = 0; ifb.dataIn = 0;
  endtask

  task automatic test_frame8();
    logic [7:0] pat;
    int n_vld;
    pat = 8'b0100_1101;  // s0..s7 = 1,0,1,1,0,0,1,0 read LSB first
    n_vld = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 1, i == 0, i == 7, pat[i]);
      if (ifa.validOut) n_vld++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== expv(k)) begin
          errors++;
          $display("FAIL frame8 dut%0d s%0d: got %h expected %h", k, i, obs(k), expv(k));
        end
      end
    end
    checks++;
    if (ifa.frameLen !== 11'd8 || n_vld != 8) begin
      errors++;
      $display("FAIL frame8_len: got len %0d valid %0d expected 8 and 8", ifa.frameLen, n_vld);
    end
    step(1, 0, 0, 0, 0);
  endtask

  task automatic test_single();
    step(1, 1, 1, 1, 1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== expv(k)) begin
        errors++;
        $display("FAIL single dut%0d: got %h expected %h", k, obs(k), expv(k));
      end
    end
    checks++;
    if (obs(0) !== {6'b111110, 11'd1}) begin
      errors++;
      $display("FAIL single_const: got %h expected %h", obs(0), {6'b111110, 11'd1});
    end
  endtask

  task automatic test_gaps_enb();
    int cyc;
    cyc = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        for (int g = 0; g < 3; g++) begin
          step(1, 0, 1, 1, 1);  // start/end must be ignored without valid
          cyc++;
          for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expv(k)) begin
              errors++;
              $display("FAIL gaps dut%0d c%0d: got %h expected %h", k, cyc, obs(k), expv(k));
            end
          end
        end
      end
      if (i == 2) begin
        for (int g = 0; g < 2; g++) begin
          step(0, 1, 0, 1, 1);
          cyc++;
          for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expv(k)) begin
              errors++;
              $display("FAIL enb_freeze dut%0d c%0d: got %h expected %h", k, cyc, obs(k), expv(k));
            end
          end
        end
      end
      step(1, 1, i == 0, i == 4, 1'(i));
      cyc++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== expv(k)) begin
          errors++;
          $display("FAIL gaps_sample dut%0d c%0d: got %h expected %h", k, cyc, obs(k), expv(k));
        end
      end
    end
    checks++;
    if (ifa.frameLen !== 11'd5) begin
      errors++;
      $display("FAIL gaps_len: got %0d expected 5", ifa.frameLen);
    end
  endtask

  task automatic test_restart();
    logic s_seq [6] = '{1, 0, 0, 1, 0, 0};
    logic e_seq [6] = '{0, 0, 0, 0, 0, 1};
    int n_err, n_end;
    n_err = 0; n_end = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 1, s_seq[i], e_seq[i], 1'($urandom_range(0, 1)));
      if (ifa.errOut) n_err++;
      if (ifa.frameEnd) n_end++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== expv(k)) begin
          errors++;
          $display("FAIL restart dut%0d s%0d: got %h expected %h", k, i, obs(k), expv(k));
        end
      end
    end
    checks++;
    if (n_err != 1 || n_end != 1 || ifa.frameLen !== 11'd3) begin
      errors++;
      $display("FAIL restart_sum: got err %0d end %0d len %0d expected 1 1 3",
               n_err, n_end, ifa.frameLen);
    end
  endtask

  task automatic test_max_len();
    int n_acc, n_err;
    n_acc = 0; n_err = 0;
    for (int i = 0; i < 6; i++) begin
      // Five samples opened by a start, then a lone end.
      step(1, 1, i == 0, i == 5, 1'($urandom_range(0, 1)));
      if (ifb.validOut) n_acc++;
      if (ifb.errOut) n_err++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== expv(k)) begin
          errors++;
          $display("FAIL max_len dut%0d s%0d: got %h expected %h", k, i, obs(k), expv(k));
        end
      end
    end
    checks++;
    if (n_acc != 4 || n_err != 2) begin
      errors++;
      $display("FAIL max_len_sum: got accepted %0d err %0d expected 4 and 2", n_acc, n_err);
    end
  endtask

  task automatic test_reset_mid();
    int n_err;
    n_err = 0;
    for (int i = 0; i < 3; i++) step(1, 1, i == 0, 0, 1);
    reset = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== 17'd0) begin
        errors++;
        $display("FAIL reset_mid dut%0d: got %h expected %h", k, obs(k), 17'd0);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1, i < 2, i == 0, i == 1, 1);
      if (ifa.errOut || ifb.errOut) n_err++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== expv(k)) begin
          errors++;
          $display("FAIL after_reset dut%0d s%0d: got %h expected %h", k, i, obs(k), expv(k));
        end
      end
    end
    checks++;
    if (n_err != 0 || ifa.frameLen !== 11'd2) begin
      errors++;
      $display("FAIL reset_mid_sum: got err %0d len %0d expected 0 and 2", n_err, ifa.frameLen);
    end
  endtask

  task automatic test_random();
    logic en, v, s, e;
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 9) != 0);
      v  = ($urandom_range(0, 9) < 7);
      s  = ($urandom_range(0, 11) == 0);
      e  = ($urandom_range(0, 7) == 0);
      step(en, v, s, e, 1'($urandom_range(0, 1)));
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== expv(k)) begin
          errors++;
          $display("FAIL random dut%0d c%0d: got %h expected %h", k, i, obs(k), expv(k));
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_frame8();
    test_single();
    test_gaps_enb();
    test_restart();
    test_max_len();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
